// File: rtl/rx_word_align_nch.sv
// Per-lane word aligner: trains each deserialised lane against a fixed
// training word, issuing bitslip pulses until it matches consistently,
// and reports per-lane lock/fail plus run-level status.
module rx_word_align_nch #(
   parameter int                NUM_LANES     = 4,
   parameter int                WORD_W        = 6,
   parameter logic [WORD_W-1:0] TRAIN_PATTERN = 6'b111000,
   parameter int                MATCH_CNT     = 16,
   parameter int                SLIP_WAIT     = 4,
   parameter int                MAX_SLIP      = 12,
   parameter int                SLIP_W        = $clog2(MAX_SLIP + 1)
) (
   input  logic                          rx_clkdiv6,
   input  logic                          rx_reset,
   input  logic [NUM_LANES*WORD_W-1:0]   rx_data,
   input  logic                          train_start,
   input  logic [NUM_LANES-1:0]          lane_mask,
   output logic [NUM_LANES-1:0]          bitslip,
   output logic [NUM_LANES-1:0]          lane_locked,
   output logic [NUM_LANES-1:0]          lane_fail,
   output logic [NUM_LANES*SLIP_W-1:0]   lane_slips,
   output logic                          train_busy,
   output logic                          train_done,
   output logic                          all_locked
);

   localparam int MATCH_W = $clog2(MATCH_CNT + 1);
   localparam int WAIT_W  = $clog2(SLIP_WAIT + 1);

   typedef enum logic [2:0] {
      ST_IDLE, ST_CHECK, ST_SLIP, ST_WAIT, ST_LOCKED, ST_FAIL
   } lane_state_t;

   lane_state_t                 state_q [NUM_LANES];
   lane_state_t                 state_d [NUM_LANES];
   logic        [MATCH_W-1:0]   match_q [NUM_LANES];
   logic        [MATCH_W-1:0]   match_d [NUM_LANES];
   logic        [SLIP_W-1:0]    slip_q  [NUM_LANES];
   logic        [SLIP_W-1:0]    slip_d  [NUM_LANES];
   logic        [WAIT_W-1:0]    wait_q  [NUM_LANES];
   logic        [WAIT_W-1:0]    wait_d  [NUM_LANES];
   logic        [NUM_LANES-1:0] mask_q;
   logic        [NUM_LANES-1:0] settled_c;
   logic                        all_done_c;
   logic        [NUM_LANES*WORD_W-1:0] rx_data_p0;

   function automatic logic [MATCH_W-1:0] sat_inc_match(input logic [MATCH_W-1:0] v);
      return (v == MATCH_W'(MATCH_CNT)) ? v : v + MATCH_W'(1);
   endfunction

   function automatic logic [SLIP_W-1:0] sat_inc_slip(input logic [SLIP_W-1:0] v);
      return (v == SLIP_W'(MAX_SLIP)) ? v : v + SLIP_W'(1);
   endfunction

   // Stage p0: single registration of the incoming lane words
   always_ff @(posedge rx_clkdiv6) begin
      rx_data_p0 <= rx_data;
   end

   // Per-lane status decode and run completion detection
   always_comb begin
      lane_locked = '0;
      lane_fail   = '0;
      settled_c   = '0;
      lane_slips  = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         lane_locked[n] = (state_q[n] == ST_LOCKED);
         lane_fail[n]   = (state_q[n] == ST_FAIL);
         settled_c[n]   = !mask_q[n] || lane_locked[n] || lane_fail[n];
         lane_slips[n*SLIP_W +: SLIP_W] = slip_q[n];
      end
      all_done_c = train_busy && (&settled_c);
   end

   // Per-lane next-state, counters and bitslip pulse
   always_comb begin
      bitslip = '0;
      for (int n = 0; n < NUM_LANES; n++) begin
         state_d[n] = state_q[n];
         match_d[n] = match_q[n];
         slip_d[n]  = slip_q[n];
         wait_d[n]  = wait_q[n];
         if (train_start) begin
            state_d[n] = lane_mask[n] ? ST_CHECK : ST_IDLE;
            match_d[n] = '0;
            slip_d[n]  = '0;
            wait_d[n]  = '0;
         end else begin
            case (state_q[n])
               ST_CHECK: begin
                  if (rx_data_p0[n*WORD_W +: WORD_W] == TRAIN_PATTERN) begin
                     match_d[n] = sat_inc_match(match_q[n]);
                     if (match_q[n] == MATCH_W'(MATCH_CNT - 1))
                        state_d[n] = ST_LOCKED;
                  end else begin
                     match_d[n] = '0;
                     state_d[n] = ST_SLIP;
                  end
               end
               ST_SLIP: begin
                  if (slip_q[n] == SLIP_W'(MAX_SLIP)) begin
                     state_d[n] = ST_FAIL;
                  end else begin
                     bitslip[n] = 1'b1;
                     slip_d[n]  = sat_inc_slip(slip_q[n]);
                     wait_d[n]  = '0;
                     state_d[n] = ST_WAIT;
                  end
               end
               ST_WAIT: begin
                  if (wait_q[n] == WAIT_W'(SLIP_WAIT - 1)) begin
                     wait_d[n]  = '0;
                     state_d[n] = ST_CHECK;
                  end else begin
                     wait_d[n] = wait_q[n] + WAIT_W'(1);
                  end
               end
               ST_LOCKED: begin
                  // Lock is re-verified only while the run is still open
                  if (train_busy && !all_done_c &&
                      rx_data_p0[n*WORD_W +: WORD_W] != TRAIN_PATTERN) begin
                     match_d[n] = '0;
                     state_d[n] = ST_CHECK;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Per-lane state and counter registers
   always_ff @(posedge rx_clkdiv6 or posedge rx_reset) begin
      if (rx_reset) begin
         for (int n = 0; n < NUM_LANES; n++) begin
            state_q[n] <= ST_IDLE;
            match_q[n] <= '0;
            slip_q[n]  <= '0;
            wait_q[n]  <= '0;
         end
      end else begin
         for (int n = 0; n < NUM_LANES; n++) begin
            state_q[n] <= state_d[n];
            match_q[n] <= match_d[n];
            slip_q[n]  <= slip_d[n];
            wait_q[n]  <= wait_d[n];
         end
      end
   end

   // Run control: busy window, done pulse and overall lock verdict
   always_ff @(posedge rx_clkdiv6 or posedge rx_reset) begin
      if (rx_reset) begin
         train_busy <= 1'b0;
         train_done <= 1'b0;
         all_locked <= 1'b0;
         mask_q     <= '0;
      end else begin
         train_done <= 1'b0;
         if (train_start) begin
            train_busy <= 1'b1;
            all_locked <= 1'b0;
            mask_q     <= lane_mask;
         end else if (all_done_c) begin
            train_busy <= 1'b0;
            train_done <= 1'b1;
            all_locked <= ~|(lane_fail & mask_q);
         end
      end
   end

endmodule

// File: doc/rx_word_align_nch.md
RX_WORD_ALIGN_NCH -- requirements
Module: rx_word_align_nch

Interface
REQ-001 SHALL have parameter NUM_LANES, default 4, number of deserialised lanes (1..16).
REQ-002 SHALL have parameter WORD_W, default 6, bits per lane word per rx_clkdiv6 cycle.
REQ-003 SHALL have parameter TRAIN_PATTERN, default 6'b111000, expected training word (WORD_W bits).
REQ-004 SHALL have parameter MATCH_CNT, default 16, consecutive matches required to lock (2..255).
REQ-005 SHALL have parameter SLIP_WAIT, default 4, idle cycles after each bitslip pulse (1..15).
REQ-006 SHALL have parameter MAX_SLIP, default 12, bitslips allowed per lane before failure; SLIP_W = clog2(MAX_SLIP+1).
REQ-007 SHALL have port rx_clkdiv6  input  1  word clock; all logic on rising edge.
REQ-008 SHALL have port rx_reset  input  1  asynchronous, active-high reset; clock rx_clkdiv6.
REQ-009 SHALL have port rx_data  input  NUM_LANES*WORD_W  lane words, lane n at [n*WORD_W +: WORD_W].
REQ-010 SHALL have port train_start  input  1  single-cycle pulse, (re)starts training of all lanes.
REQ-011 SHALL have port lane_mask  input  NUM_LANES  1 = lane trained, 0 = lane ignored; sampled on train_start.
REQ-012 SHALL have port bitslip  output  NUM_LANES  one-cycle bitslip request per lane to deserialiser.
REQ-013 SHALL have port lane_locked  output  NUM_LANES  lane in LOCKED.
REQ-014 SHALL have port lane_fail  output  NUM_LANES  lane in FAIL.
REQ-015 SHALL have port lane_slips  output  NUM_LANES*SLIP_W  bitslips issued per lane in current run.
REQ-016 SHALL have ports train_busy, train_done, all_locked  output  1 each  run status.

Function
REQ-017 SHALL register rx_data once; all compares use registered word (1-cycle compare latency).
REQ-018 SHALL implement per-lane FSM states IDLE, CHECK, SLIP, WAIT, LOCKED, FAIL.
REQ-019 On train_start, each unmasked lane SHALL enter CHECK with match and slip counters cleared; masked lanes SHALL enter IDLE.
REQ-020 CHECK: match increments match counter; MATCH_CNT-th consecutive match -> LOCKED; mismatch -> SLIP, match counter cleared.
REQ-021 SLIP: assert bitslip for exactly one cycle, increment slip counter, -> WAIT; if slip counter already equals MAX_SLIP -> FAIL without pulse.
REQ-022 WAIT: hold SLIP_WAIT cycles, no compares, then -> CHECK; bitslip SHALL never assert on consecutive cycles.
REQ-023 LOCKED while train_busy: mismatch -> CHECK (no slip, match counter cleared); after train_done state SHALL hold.
REQ-024 FAIL and IDLE SHALL be held until next train_start or reset.
REQ-025 train_busy SHALL be 1 from cycle after train_start until train_done; train_done SHALL be a one-cycle pulse when every unmasked lane is LOCKED or FAIL.
REQ-026 all_locked SHALL update with train_done: 1 iff no unmasked lane FAIL; holds until next train_start (cleared on it).
REQ-027 lane_mask all zero: train_done SHALL pulse cycle after train_start with all_locked=1.
REQ-028 train_start while train_busy SHALL abort current run and restart all lanes per REQ-019; no train_done for aborted run.
REQ-029 Masked lanes: bitslip, lane_locked, lane_fail held 0; lane_slips held 0.
REQ-030 Counters SHALL saturate, never wrap.

Reset
REQ-031 rx_reset asserted SHALL immediately force all FSMs to IDLE and all outputs and counters to 0.
REQ-032 rx_reset mid-run SHALL abort training; no train_done until new train_start after release.
REQ-033 After rx_reset release, block SHALL stay idle until train_start.

Verification
REQ-034 4 lanes, all data = TRAIN_PATTERN, train_start -> no bitslip, train_done 17 cycles after pulse, all_locked=1, lane_slips=0.
REQ-035 Lane 2 data rotated by 3 bits, model rotates per slip -> lane 2 gets 3 bitslip pulses spaced SLIP_WAIT+2 cycles, lane_slips[2]=3, all_locked=1.
REQ-036 Lane 1 never matches -> 12 bitslips then lane_fail[1]=1, train_done pulses, all_locked=0.
REQ-037 lane_mask=4'b0101, lanes 1/3 garbage -> lanes 1/3 never slip, all_locked=1.
REQ-038 train_start re-pulsed mid-run, then rx_reset mid-run -> counters cleared each time, no stale train_done, outputs 0 under reset.
